// File: rtl/fp32_pkg.sv
// Shared FP32 constants, field widths and accumulator state encoding.
package fp32_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = FRAC_W + 1;  // hidden bit + fraction
  localparam int unsigned ALN_W  = SIG_W + 3;   // + guard, round, sticky
  localparam int unsigned SUM_W  = ALN_W + 1;   // + carry-out
  localparam int unsigned LZC_W  = 5;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
  localparam int          FP32_BIAS    = 127;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    NORM,
    DONE
  } acc_state_t;

endpackage

// File: rtl/fp32_dot_accumulator_lzc28.sv
// Combinational leading-zero counter over the 28-bit adder sum; all-zero input yields 28.
module lzc28
  import fp32_pkg::*;
(
  input  logic [SUM_W-1:0] value,
  output logic [LZC_W-1:0] count
);

  logic found;

  // Scan from the MSB and stop at the first set bit.
  always_comb begin
    count = 5'd28;
    found = 1'b0;
    for (int unsigned i = 0; i < SUM_W; i++) begin
      if (!found && value[SUM_W-1-i]) begin
        count = 5'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp32_dot_accumulator.sv
// Sequential FP32 accumulator: D = C + sum(A_i * B_i), one product per handshake,
// two-stage align/normalize add, round-toward-zero, denormals flushed to zero.
module fp32_dot_accumulator
  import fp32_pkg::*;
#(
  parameter int FLUSH_DENORM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_first,
  input  logic        in_last,
  input  logic [31:0] acc_init,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  acc_state_t state;

  logic [31:0]      x_q, y_q, acc, out_data_q;
  logic             last_q, out_valid_q;
  logic [SUM_W-1:0] sum_q;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q;
  logic             nan_q, inf_q, inf_sign_q, zero_q, zero_sign_q;

  // Operand fields and classification
  logic              x_sign, y_sign;
  logic [EXP_W-1:0]  x_exp, y_exp;
  logic [FRAC_W-1:0] x_frac, y_frac;
  logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_big;

  assign {x_sign, x_exp, x_frac} = x_q;
  assign {y_sign, y_exp, y_frac} = y_q;

  assign x_zero = (x_exp == '0) && ((FLUSH_DENORM != 0) || (x_frac == '0));
  assign y_zero = (y_exp == '0) && ((FLUSH_DENORM != 0) || (y_frac == '0));
  assign x_inf  = (x_exp == '1) && (x_frac == '0);
  assign y_inf  = (y_exp == '1) && (y_frac == '0);
  assign x_nan  = (x_exp == '1) && (x_frac != '0);
  assign y_nan  = (y_exp == '1) && (y_frac != '0);
  assign x_big  = {x_exp, x_frac} >= {y_exp, y_frac};

  logic              big_sign, small_sign, big_zero, small_zero;
  logic [EXP_W-1:0]  big_exp, small_exp, diff;
  logic [FRAC_W-1:0] big_frac, small_frac;
  logic [SIG_W-1:0]  big_sig, small_sig;
  logic [ALN_W-1:0]  big_aln, small_ext, shifted, lost_mask, small_aln;
  logic [SUM_W-1:0]  sum;

  // Align stage: order by magnitude, shift the smaller significand with sticky, add/subtract.
  always_comb begin
    big_sign   = x_big ? x_sign : y_sign;
    big_exp    = x_big ? x_exp  : y_exp;
    big_frac   = x_big ? x_frac : y_frac;
    big_zero   = x_big ? x_zero : y_zero;
    small_sign = x_big ? y_sign : x_sign;
    small_exp  = x_big ? y_exp  : x_exp;
    small_frac = x_big ? y_frac : x_frac;
    small_zero = x_big ? y_zero : x_zero;

    big_sig   = big_zero   ? '0 : {big_exp != '0, big_frac};
    small_sig = small_zero ? '0 : {small_exp != '0, small_frac};
    diff      = big_exp - small_exp;
    big_aln   = {big_sig, 3'b000};
    small_ext = {small_sig, 3'b000};
    shifted   = '0;
    lost_mask = '0;

    if (diff >= 8'(ALN_W)) begin
      small_aln = {{(ALN_W-1){1'b0}}, small_sig != '0};
    end else begin
      shifted   = small_ext >> diff;
      lost_mask = (27'd1 << diff) - 27'd1;
      small_aln = {shifted[ALN_W-1:1], shifted[0] | ((small_ext & lost_mask) != '0)};
    end

    if (big_sign == small_sign) sum = {1'b0, big_aln} + {1'b0, small_aln};
    else                        sum = {1'b0, big_aln} - {1'b0, small_aln};
  end

  // Normalize stage
  logic [LZC_W-1:0]  lz;
  logic [SUM_W-1:0]  norm_sig;
  logic signed [9:0] norm_exp;
  logic [31:0]       result;
  logic              unused_norm_bits;

  lzc28 u_lzc28 (
    .value (sum_q),
    .count (lz)
  );

  assign norm_sig         = sum_q << lz;
  assign norm_exp         = $signed({2'b00, exp_q}) + 10'sd1 - $signed({5'b00000, lz});
  assign unused_norm_bits = ^{norm_sig[SUM_W-1], norm_sig[3:0]};

  // Select the final encoding. Zero-operand and cancellation cases are resolved
  // before the exponent checks because a zero sum has no meaningful exponent.
  always_comb begin
    result = {sign_q, norm_exp[EXP_W-1:0], norm_sig[SUM_W-2:4]};
    if (nan_q)                    result = FP32_QNAN;
    else if (inf_q)               result = {inf_sign_q, FP32_POS_INF[30:0]};
    else if (zero_q)              result = {zero_sign_q, 31'd0};
    else if (sum_q == '0)         result = '0;
    else if (norm_exp >= 10'sd255) result = {sign_q, FP32_POS_INF[30:0]};
    else if (norm_exp <= 10'sd0)  result = '0;
  end

  // Control FSM with registered operands, pipeline state and output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      last_q      <= 1'b0;
      acc         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
      inf_sign_q  <= 1'b0;
      zero_q      <= 1'b0;
      zero_sign_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q    <= in_data;
            y_q    <= in_first ? acc_init : acc;
            last_q <= in_last;
            state  <= ALIGN;
          end
        end
        ALIGN: begin
          sum_q       <= sum;
          sign_q      <= big_sign;
          exp_q       <= big_exp;
          nan_q       <= x_nan | y_nan | (x_inf & y_inf & (x_sign != y_sign));
          inf_q       <= x_inf | y_inf;
          inf_sign_q  <= x_inf ? x_sign : y_sign;
          zero_q      <= x_zero & y_zero;
          zero_sign_q <= x_sign & y_sign;
          state       <= NORM;
        end
        NORM: begin
          acc <= result;
          if (last_q) begin
            out_data_q  <= result;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Self-checking bench: exact-arithmetic FP32 reference model, scoreboard compare thread,
// directed scenarios plus randomized sequences with random output backpressure.
module tb_fp32_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0, acc_init = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;

  int unsigned n_chk = 0, n_fail = 0;
  logic [31:0] model_acc = '0;
  logic [31:0] exp_q[$];
  bit          rand_bp = 1'b0;

  always #5 clk = ~clk;

  fp32_dot_accumulator #(.FLUSH_DENORM(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .acc_init  (acc_init),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Reference: exact sum on a 2^-149 integer grid, then truncate to 24 significant bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, sr;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic za, zb, ia, ib, na, nb;
    logic [279:0] ma, mb, m;
    int p, e;
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    za = (ea == 8'd0);  zb = (eb == 8'd0);
    ia = (ea == 8'hFF) && (fa == 23'd0);  ib = (eb == 8'hFF) && (fb == 23'd0);
    na = (ea == 8'hFF) && (fa != 23'd0);  nb = (eb == 8'hFF) && (fb != 23'd0);
    if (na || nb || (ia && ib && (sa != sb))) return 32'h7FC00000;
    if (ia) return {sa, 8'hFF, 23'd0};
    if (ib) return {sb, 8'hFF, 23'd0};
    if (za && zb) return {sa & sb, 31'd0};
    ma = za ? '0 : (280'({1'b1, fa}) << (ea - 8'd1));
    mb = zb ? '0 : (280'({1'b1, fb}) << (eb - 8'd1));
    if (sa == sb)     begin m = ma + mb; sr = sa; end
    else if (ma >= mb) begin m = ma - mb; sr = sa; end
    else              begin m = mb - ma; sr = sb; end
    if (m == '0) return 32'h0;
    p = 0;
    for (int i = 0; i < 280; i++) if (m[i]) p = i;
    e = p - 22;
    if (e >= 255) return {sr, 8'hFF, 23'd0};
    if (e <= 0) return 32'h0;
    return {sr, 8'(e), 23'(m >> (p - 23))};
  endfunction

  function automatic logic [31:0] rand_fp();
    int unsigned k;
    logic s;
    logic [7:0] e;
    logic [22:0] fr;
    k  = $urandom_range(0, 99);
    s  = 1'($urandom);
    fr = 23'($urandom);
    if (k < 5)       e = 8'd0;
    else if (k < 8)  begin e = 8'hFF; fr = '0; end
    else if (k < 10) begin e = 8'hFF; fr[22] = 1'b1; end
    else if (k < 16) e = 8'($urandom_range(245, 254));
    else if (k < 22) e = 8'($urandom_range(1, 8));
    else             e = 8'($urandom_range(118, 136));
    return {s, e, fr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every cycle with a valid result, compare against the oldest expected value.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(out_valid), 32'd0);
        end else begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic bp_loop();
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Offer one element, update the model, and check the busy window that follows.
  task automatic send(input logic [31:0] d, input logic [31:0] init, input bit f, input bit l);
    int unsigned w;
    logic [31:0] y, r;
    w = 0;
    while (!in_ready && w < 100) begin step(); w++; end
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1; in_data = d; acc_init = init; in_first = f; in_last = l;
      step();
      y = f ? init : model_acc;
      r = ref_add(d, y);
      model_acc = r;
      if (l) exp_q.push_back(r);
      // Junk on the inputs while busy must be ignored.
      for (int i = 0; i < 2; i++) begin
        check("busy_in_ready", 32'(in_ready), 32'd0);
        check("busy_out_valid", 32'(out_valid), 32'd0);
        in_data = $urandom; acc_init = $urandom;
        in_first = 1'($urandom); in_last = 1'($urandom);
        step();
      end
      in_valid = 1'b0;
      if (l) check("out_valid_t3", 32'(out_valid), 32'd1);
      else   check("in_ready_t3", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int unsigned w;
    int unsigned seq_left;
    bit f, l;
    logic [31:0] d;

    fork
      compare_loop();
      bp_loop();
    join_none

    // Pin the reference model to hand-computed values.
    check("pin_one_plus_zero", ref_add(32'h3F800000, 32'h00000000), 32'h3F800000);
    check("pin_chain_3p5", ref_add(32'h3F000000, ref_add(32'h40000000, 32'h3F800000)), 32'h40600000);
    check("pin_cancel", ref_add(32'h3F800000, 32'hBF800000), 32'h00000000);
    check("pin_rtz", ref_add(32'h3F800000, 32'h33800000), 32'h3F800000);
    check("pin_rtz_sub", ref_add(32'h3F800000, 32'hA8000000), 32'h3F7FFFFF);
    check("pin_inf_minus_inf", ref_add(32'h7F800000, 32'hFF800000), 32'h7FC00000);
    check("pin_overflow", ref_add(32'h7F7FFFFF, 32'h7F7FFFFF), 32'h7F800000);
    check("pin_nan", ref_add(32'h7FC12345, 32'h3F800000), 32'h7FC00000);
    check("pin_neg_zeros", ref_add(32'h80000000, 32'h80000000), 32'h80000000);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Single first+last element and latency
    send(32'h3F800000, 32'h0, 1'b1, 1'b1);
    check("lit_first_last", out_data, 32'h3F800000);
    step();

    // Three-element sequence
    send(32'h3F800000, 32'h0, 1'b1, 1'b0);
    send(32'h40000000, 32'h0, 1'b0, 1'b0);
    send(32'h3F000000, 32'h0, 1'b0, 1'b1);
    check("lit_seq_3p5", out_data, 32'h40600000);
    step();

    // Cancellation, truncation and special values
    send(32'h3F800000, 32'hBF800000, 1'b1, 1'b1);
    send(32'h3F800000, 32'h33800000, 1'b1, 1'b1);
    send(32'h7F800000, 32'hFF800000, 1'b1, 1'b1);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b1);
    check("lit_overflow", out_data, 32'h7F800000);
    send(32'h3F800000, 32'hFFC00001, 1'b1, 1'b1);
    check("lit_nan", out_data, 32'h7FC00000);
    step();

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40400000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_data", out_data, 32'h40800000);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);

    // Reset during NORM discards the in-flight element and clears the accumulator
    in_valid = 1'b1; in_data = 32'h42000000; acc_init = 32'h0; in_first = 1'b1; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    model_acc = '0;
    step();
    send(32'h3F800000, 32'h12345678, 1'b0, 1'b1);
    check("lit_acc_cleared", out_data, 32'h3F800000);
    send(32'h40000000, 32'h0, 1'b1, 1'b1);
    check("lit_after_reset", out_data, 32'h40000000);
    step();

    // Randomized sequences with random backpressure
    rand_bp = 1'b1;
    seq_left = 0;
    for (int n = 0; n < 400; n++) begin
      if (seq_left == 0) begin
        seq_left = $urandom_range(1, 4);
        f = ($urandom_range(0, 4) != 0);
      end else begin
        f = 1'b0;
      end
      seq_left--;
      l = (seq_left == 0);
      d = rand_fp();
      if (!f && $urandom_range(0, 11) == 0) d = model_acc ^ 32'h80000000;
      send(d, rand_fp(), f, l);
    end

    // Drain
    rand_bp = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin step(); w++; end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
